// File: rtl/fifologic_pkg.sv
// ============================================================================
// Module   : fifologic_pkg
// Purpose  : Shared state encoding, output patterns and default pulse widths
//            for the fifo_logic_gated USB FIFO bridge controller.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package fifologic_pkg;

    localparam int c_CNT_W         = 8;
    localparam int c_RD_PULSE_DEF  = 2;
    localparam int c_WR_PULSE_DEF  = 2;
    localparam int c_FETCH_DEF     = 1;
    localparam int c_RECOV_DEF     = 2;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_R_STROBE = 3'd1,
        ST_R_WRITE  = 3'd2,
        ST_W_FETCH  = 3'd3,
        ST_W_STROBE = 3'd4,
        ST_W_HOLD   = 3'd5,
        ST_RECOVER  = 3'd6
    } state_t;

    typedef struct packed {
        logic rd;
        logic wr;
        logic wa;
        logic rb;
        logic d1;
        logic d2;
    } out_t;

    // Output pattern driven while in each state (fields: rd wr wa rb d1 d2)
    localparam out_t c_IDLE_OUT    = '{rd: 1'b1, wr: 1'b0, wa: 1'b1, rb: 1'b1, d1: 1'b0, d2: 1'b0};
    localparam out_t c_RSTROBE_OUT = '{rd: 1'b0, wr: 1'b0, wa: 1'b1, rb: 1'b1, d1: 1'b0, d2: 1'b1};
    localparam out_t c_RWRITE_OUT  = '{rd: 1'b0, wr: 1'b0, wa: 1'b0, rb: 1'b1, d1: 1'b0, d2: 1'b1};
    localparam out_t c_WFETCH_OUT  = '{rd: 1'b1, wr: 1'b0, wa: 1'b1, rb: 1'b0, d1: 1'b1, d2: 1'b0};
    localparam out_t c_WSTROBE_OUT = '{rd: 1'b1, wr: 1'b1, wa: 1'b1, rb: 1'b1, d1: 1'b1, d2: 1'b0};
    localparam out_t c_WHOLD_OUT   = '{rd: 1'b1, wr: 1'b0, wa: 1'b1, rb: 1'b1, d1: 1'b1, d2: 1'b0};

endpackage

`default_nettype wire

// File: rtl/fifo_logic_gated_flag_sync.sv
// ============================================================================
// Module   : flag_sync
// Purpose  : 2-flop synchronizer with a configurable reset value. Only
//            compiled when FIFOLOGIC_FLAG_SYNC_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

`ifdef FIFOLOGIC_FLAG_SYNC_EN
module flag_sync #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_meta <= RST_VAL;
            r_sync <= RST_VAL;
        end else begin
            r_meta <= d;
            r_sync <= r_meta;
        end
    end

    assign q = r_sync;

endmodule
`endif

`default_nettype wire

// File: rtl/fifo_logic_gated.sv
// ============================================================================
// Module   : fifo_logic_gated
// Purpose  : Strobe/bus-enable FSM bridging an FT2232H async FIFO to FIFO A
//            (USB->host) and FIFO B (host->USB). Optional flag synchronizers
//            are enabled with the FIFOLOGIC_FLAG_SYNC_EN macro.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fifo_logic_gated
    import fifologic_pkg::*;
#(
    parameter int RD_PULSE = c_RD_PULSE_DEF,
    parameter int WR_PULSE = c_WR_PULSE_DEF,
    parameter int FETCH    = c_FETCH_DEF,
    parameter int RECOV    = c_RECOV_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic RXF,
    input  logic TXE,
    input  logic FFA,
    input  logic EFB,
    output logic RD,
    output logic WR,
    output logic WA,
    output logic RB,
    output logic D1,
    output logic D2
);

    localparam logic [c_CNT_W-1:0] c_RD_LOAD    = c_CNT_W'(RD_PULSE - 1);
    localparam logic [c_CNT_W-1:0] c_WR_LOAD    = c_CNT_W'(WR_PULSE - 1);
    localparam logic [c_CNT_W-1:0] c_FETCH_LOAD = c_CNT_W'(FETCH - 1);
    localparam logic [c_CNT_W-1:0] c_RECOV_LOAD = c_CNT_W'(RECOV - 1);

    logic w_rxf;
    logic w_txe;
    logic w_ffa;
    logic w_efb;

`ifdef FIFOLOGIC_FLAG_SYNC_EN
    // Reset values present "no request" to the FSM until real flags arrive
    flag_sync #(.RST_VAL(1'b1)) u_sync_rxf (.clk(clk), .rst(rst), .d(RXF), .q(w_rxf));
    flag_sync #(.RST_VAL(1'b1)) u_sync_txe (.clk(clk), .rst(rst), .d(TXE), .q(w_txe));
    flag_sync #(.RST_VAL(1'b0)) u_sync_ffa (.clk(clk), .rst(rst), .d(FFA), .q(w_ffa));
    flag_sync #(.RST_VAL(1'b0)) u_sync_efb (.clk(clk), .rst(rst), .d(EFB), .q(w_efb));
`else
    assign w_rxf = RXF;
    assign w_txe = TXE;
    assign w_ffa = FFA;
    assign w_efb = EFB;
`endif

    state_t               r_state;
    out_t                 r_out;
    logic [c_CNT_W-1:0]   r_cnt;
    logic                 r_prefer_read;

    logic w_rd_req;
    logic w_wr_req;
    logic w_pick_read;

    assign w_rd_req    = !w_rxf && w_ffa;
    assign w_wr_req    = !w_txe && w_efb;
    // Round-robin: on contention the pointer decides; a lone request always wins
    assign w_pick_read = w_rd_req && (!w_wr_req || r_prefer_read);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_out         <= c_IDLE_OUT;
            r_cnt         <= '0;
            r_prefer_read <= 1'b1;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_pick_read) begin
                        r_state       <= ST_R_STROBE;
                        r_out         <= c_RSTROBE_OUT;
                        r_cnt         <= c_RD_LOAD;
                        r_prefer_read <= 1'b0;
                    end else if (w_wr_req) begin
                        r_state       <= ST_W_FETCH;
                        r_out         <= c_WFETCH_OUT;
                        r_cnt         <= c_FETCH_LOAD;
                        r_prefer_read <= 1'b1;
                    end
                end
                ST_R_STROBE: begin
                    if (r_cnt == '0) begin
                        r_state <= ST_R_WRITE;
                        r_out   <= c_RWRITE_OUT;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                ST_R_WRITE: begin
                    r_state <= ST_RECOVER;
                    r_out   <= c_IDLE_OUT;
                    r_cnt   <= c_RECOV_LOAD;
                end
                ST_W_FETCH: begin
                    if (r_cnt == '0) begin
                        r_state <= ST_W_STROBE;
                        r_out   <= c_WSTROBE_OUT;
                        r_cnt   <= c_WR_LOAD;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                ST_W_STROBE: begin
                    if (r_cnt == '0) begin
                        r_state <= ST_W_HOLD;
                        r_out   <= c_WHOLD_OUT;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                ST_W_HOLD: begin
                    r_state <= ST_RECOVER;
                    r_out   <= c_IDLE_OUT;
                    r_cnt   <= c_RECOV_LOAD;
                end
                ST_RECOVER: begin
                    if (r_cnt == '0) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_out   <= c_IDLE_OUT;
                end
            endcase
        end
    end

    assign RD = r_out.rd;
    assign WR = r_out.wr;
    assign WA = r_out.wa;
    assign RB = r_out.rb;
    assign D1 = r_out.d1;
    assign D2 = r_out.d2;

endmodule

`default_nettype wire

// File: tb/tb_fifo_logic_gated.sv
// ============================================================================
// Module   : tb_fifo_logic_gated
// Purpose  : Directed self-checking bench for fifo_logic_gated with a
//            transfer-order scoreboard and pulse-shape monitor.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fifo_logic_gated;

    localparam int RD_PULSE = 2;
    localparam int WR_PULSE = 2;
    localparam int FETCH    = 1;
    localparam int RECOV    = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic RXF = 1'b1;
    logic TXE = 1'b1;
    logic FFA = 1'b0;
    logic EFB = 1'b0;
    logic RD, WR, WA, RB, D1, D2;

    always #5 clk = ~clk;

    fifo_logic_gated #(
        .RD_PULSE(RD_PULSE),
        .WR_PULSE(WR_PULSE),
        .FETCH   (FETCH),
        .RECOV   (RECOV)
    ) dut (
        .clk(clk), .rst(rst),
        .RXF(RXF), .TXE(TXE), .FFA(FFA), .EFB(EFB),
        .RD(RD), .WR(WR), .WA(WA), .RB(RB), .D1(D1), .D2(D2)
    );

    int n_assert = 0;
    int n_fail   = 0;

    // Expected transfer order: 0 = read (USB->A), 1 = write (B->USB)
    int sb[$];

    logic p_rd = 1'b1, p_wr = 1'b0, p_wa = 1'b1, p_rb = 1'b1, p_d1 = 1'b0;
    int n_rd = 0, n_wr = 0, n_wa = 0, n_rb = 0;
    int rd_len = 0, wa_cnt = 0, wa_pos = 0, rb_len = 0, wr_len = 0, d1_len = 0;
    int idle_len = 0;
    bit have_end = 0, chk_gap = 0, abort = 0;
    bit ev_wr_fall = 0, ev_rd_rise = 0, ev_rd_fall = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic start_xfer(input int kind);
        int e;
        if (chk_gap && have_end) chk("recover_gap", idle_len, RECOV + 1);
        if (sb.size() == 0) begin
            chk("unexpected_xfer", kind, 2);
        end else begin
            e = sb.pop_front();
            chk("xfer_order", kind, e);
        end
    endtask

    task automatic xfer_end();
        have_end = 1;
        idle_len = 0;
    endtask

    // One clock: sample just after the edge, check invariants and pulse shapes
    task automatic tick();
        @(posedge clk);
        #1;
        ev_wr_fall = 0; ev_rd_rise = 0; ev_rd_fall = 0;
        chk("d1_d2_overlap", {31'd0, D1 & D2}, 0);
        chk("d2_tracks_rd", {31'd0, D2}, {31'd0, ~RD});
        chk("wa_outside_rd", {31'd0, !WA && RD}, 0);
        chk("rb_without_d1", {31'd0, !RB && !D1}, 0);
        chk("wr_without_d1", {31'd0, WR && !D1}, 0);

        if (p_rd && !RD) begin
            n_rd++; ev_rd_fall = 1; rd_len = 0; wa_cnt = 0; wa_pos = 0;
            start_xfer(0);
        end
        if (!RD) begin
            rd_len++;
            if (!WA) begin wa_cnt++; wa_pos = rd_len; end
        end
        if (p_wa && !WA) n_wa++;
        if (p_rb && !RB) begin
            n_rb++; rb_len = 0;
            chk("d1_rise_at_rb_fall", {30'd0, p_d1, D1}, 1);
            start_xfer(1);
        end
        if (!RB) rb_len++;
        if (!p_rb && RB) chk("rb_low_len", rb_len, FETCH);
        if (!p_wr && WR) begin n_wr++; wr_len = 0; end
        if (WR) wr_len++;
        if (p_wr && !WR) begin ev_wr_fall = 1; chk("wr_high_len", wr_len, WR_PULSE); end
        if (!p_d1 && D1) d1_len = 0;
        if (D1) d1_len++;

        if (!p_rd && RD) begin
            ev_rd_rise = 1;
            if (!abort) begin
                chk("rd_low_len", rd_len, RD_PULSE + 1);
                chk("wa_pulses_in_rd", wa_cnt, 1);
                chk("wa_in_last_rd_cycle", wa_pos, RD_PULSE + 1);
            end
            xfer_end();
        end
        if (p_d1 && !D1) begin
            chk("d1_high_len", d1_len, FETCH + WR_PULSE + 1);
            xfer_end();
        end
        if (RD && !WR && WA && RB && !D1 && !D2) idle_len++;

        p_rd = RD; p_wr = WR; p_wa = WA; p_rb = RB; p_d1 = D1;
    endtask

    task automatic wait_ev(input int which, input string tag);
        int k;
        bit got;
        k = 0;
        got = 0;
        while (!got && k < 300) begin
            tick();
            k++;
            got = (which == 0) ? ev_wr_fall : (which == 1) ? ev_rd_rise : ev_rd_fall;
        end
        chk(tag, {31'd0, got}, 1);
    endtask

    initial begin
        int b_rd, b_wr, b_wa, b_rb, k;

        // Reset and idle
        repeat (3) tick();
        chk("reset_rd", {31'd0, RD}, 1);
        chk("reset_wr", {31'd0, WR}, 0);
        chk("reset_wa", {31'd0, WA}, 1);
        chk("reset_rb", {31'd0, RB}, 1);
        chk("reset_d1", {31'd0, D1}, 0);
        chk("reset_d2", {31'd0, D2}, 0);
        rst = 1'b0;
        repeat (100) tick();
        chk("idle_rd_pulses", n_rd, 0);
        chk("idle_rb_pulses", n_rb, 0);
        chk("idle_wr_pulses", n_wr, 0);
        chk("idle_wa_pulses", n_wa, 0);

        // Write path, 20 bytes
        b_rd = n_rd; b_wr = n_wr; b_wa = n_wa; b_rb = n_rb;
        FFA = 1'b1; EFB = 1'b1; RXF = 1'b1; TXE = 1'b0;
        for (int i = 0; i < 20; i++) sb.push_back(1);
        for (int i = 0; i < 20; i++) begin
            wait_ev(0, "wait_wr_fall");
            TXE = 1'b1;
            if (i < 19) begin
                repeat (63) tick();
                TXE = 1'b0;
            end
        end
        repeat (20) tick();
        chk("wr_phase_rb_count", n_rb - b_rb, 20);
        chk("wr_phase_wr_count", n_wr - b_wr, 20);
        chk("wr_phase_rd_count", n_rd - b_rd, 0);
        chk("wr_phase_wa_count", n_wa - b_wa, 0);
        chk("wr_phase_sb_empty", sb.size(), 0);

        // Read path, 40 bytes
        b_rd = n_rd; b_wr = n_wr; b_wa = n_wa; b_rb = n_rb;
        RXF = 1'b0;
        for (int i = 0; i < 40; i++) sb.push_back(0);
        for (int i = 0; i < 40; i++) begin
            wait_ev(1, "wait_rd_rise");
            RXF = 1'b1;
            if (i < 39) begin
                repeat (63) tick();
                RXF = 1'b0;
            end
        end
        repeat (20) tick();
        chk("rd_phase_rd_count", n_rd - b_rd, 40);
        chk("rd_phase_wa_count", n_wa - b_wa, 40);
        chk("rd_phase_rb_count", n_rb - b_rb, 0);
        chk("rd_phase_wr_count", n_wr - b_wr, 0);
        chk("rd_phase_sb_empty", sb.size(), 0);

        // Contention after reset: read first, then alternate
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        b_rd = n_rd; b_rb = n_rb;
        chk_gap = 1; have_end = 0;
        for (int i = 0; i < 6; i++) sb.push_back(i % 2);
        RXF = 1'b0; TXE = 1'b0;
        k = 0;
        while (sb.size() != 0 && k < 400) begin
            tick();
            k++;
        end
        chk("alt_sb_drained", sb.size(), 0);
        RXF = 1'b1; TXE = 1'b1;
        repeat (20) tick();
        chk_gap = 0;
        chk("alt_rd_count", n_rd - b_rd, 3);
        chk("alt_rb_count", n_rb - b_rb, 3);

        // Blocked paths
        b_rd = n_rd; b_wr = n_wr; b_rb = n_rb;
        RXF = 1'b0; FFA = 1'b0; TXE = 1'b1; EFB = 1'b1;
        repeat (50) tick();
        chk("a_full_blocks_rd", n_rd - b_rd, 0);
        RXF = 1'b1; FFA = 1'b1; TXE = 1'b0; EFB = 1'b0;
        repeat (50) tick();
        chk("b_empty_blocks_rb", n_rb - b_rb, 0);
        chk("b_empty_blocks_wr", n_wr - b_wr, 0);

        // Reset during R_STROBE abandons the byte
        TXE = 1'b1; RXF = 1'b0; FFA = 1'b1;
        sb.push_back(0);
        b_rd = n_rd; b_wa = n_wa;
        wait_ev(2, "wait_rd_fall");
        rst = 1'b1; abort = 1; RXF = 1'b1;
        tick();
        chk("abort_rd_high", {31'd0, RD}, 1);
        chk("abort_d2_low", {31'd0, D2}, 0);
        chk("abort_wa_high", {31'd0, WA}, 1);
        rst = 1'b0;
        abort = 0;
        repeat (10) tick();
        chk("abort_no_wa", n_wa - b_wa, 0);
        chk("abort_rd_count", n_rd - b_rd, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
